// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: EX_MEM control bit positions, the MEM-stage FSM
// encoding and a byte-reverse helper.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// D-cache port of the MEM stage, grouped so the cache model and the stage bind to
// one bundle.
interface mem_stage_if #(
    parameter int ADDR_W = 30
);
    // Request/ready: ren or wen acts as valid and holds stable with addr/wdata
    // while DCACHE_stall is high. The access completes in the first requesting
    // cycle that sees DCACHE_stall low, and DCACHE_rdata is valid in that cycle.
    logic              DCACHE_ren;
    logic              DCACHE_wen;
    logic [ADDR_W-1:0] DCACHE_addr;
    logic [31:0]       DCACHE_wdata;
    logic              DCACHE_stall;
    logic [31:0]       DCACHE_rdata;

    modport master (
        output DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
        input  DCACHE_stall, DCACHE_rdata
    );

    modport slave (
        input  DCACHE_ren, DCACHE_wen, DCACHE_addr, DCACHE_wdata,
        output DCACHE_stall, DCACHE_rdata
    );
endinterface

// File: rtl/mem_stage_byte_swap32.sv
// Combinational 32-bit byte reversal with a parameterised bypass. It bridges the
// little-endian core and the big-endian memory.
module byte_swap32
    import pipe_pkg::*;
#(
    parameter bit EN = 1'b1
) (
    input  logic [31:0] d_i,
    output logic [31:0] d_o
);
    assign d_o = EN ? bswap32(d_i) : d_i;
endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline. It issues D-cache accesses, freezes the pipeline
// while one is outstanding, and parks completed load data while another source
// holds the pipeline.
module mem_stage
    import pipe_pkg::*;
#(
    parameter bit ENDIAN_SWAP = 1'b1,
    parameter int ADDR_W      = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  ctrl_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        ext_stall_i,
    mem_stage_if.master dc,
    output logic [1:0]  ctrl_o,
    output logic [31:0] WBdata_o,
    output logic [4:0]  RDaddr_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [31:0] stall_cnt_o,
    output mem_state_e  state_o
);
    mem_state_e  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        misalign_q, misalign_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        mem_req, in_hold, completes;
    logic [31:0] rdata_sw, load_data;

    byte_swap32 #(.EN(ENDIAN_SWAP)) u_swap_rd (.d_i(dc.DCACHE_rdata), .d_o(rdata_sw));
    byte_swap32 #(.EN(ENDIAN_SWAP)) u_swap_wr (.d_i(RS2data_i),       .d_o(dc.DCACHE_wdata));

    assign mem_req   = ctrl_i[CTRL_MEMREAD] | ctrl_i[CTRL_MEMWRITE];
    assign in_hold   = (state_q == HOLD);
    assign completes = mem_req & ~in_hold & ~dc.DCACHE_stall;

    // Requests drop immediately under reset because the cache resets in the same cycle.
    assign dc.DCACHE_ren  = rst_n & ~in_hold & ctrl_i[CTRL_MEMREAD];
    assign dc.DCACHE_wen  = rst_n & ~in_hold & ctrl_i[CTRL_MEMWRITE] & ~ctrl_i[CTRL_MEMREAD];
    assign dc.DCACHE_addr = ALUResult_i[ADDR_W+1:2];

    assign stall_o   = dc.DCACHE_stall & mem_req & ~in_hold;
    assign load_data = in_hold ? hold_q : rdata_sw;
    assign WBdata_o  = ctrl_i[CTRL_MEMTOREG] ? load_data : ALUResult_i;
    assign ctrl_o    = {ctrl_i[CTRL_REGWRITE], ctrl_i[CTRL_MEMTOREG]};
    assign RDaddr_o  = RDaddr_i;

    assign misalign_o  = misalign_q;
    assign stall_cnt_o = stall_cnt_q;
    assign state_o     = state_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        misalign_d  = misalign_q | (mem_req & (ALUResult_i[1:0] != 2'b00));
        stall_cnt_d = (stall_o && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1
                                                                : stall_cnt_q;
        unique case (state_q)
            IDLE, WAIT: begin
                if (completes) begin
                    // Park the data so the frozen pipeline never re-issues the access.
                    if (ext_stall_i) begin
                        state_d = HOLD;
                        hold_d  = rdata_sw;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (mem_req) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!ext_stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 32'd0;
            misalign_q  <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            misalign_q  <= misalign_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hit, miss, hold, misalignment, reset mid-access and
// ALU pass-through, with hand-computed expectations.
module tb_mem_stage;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ctrl_i;
  logic [31:0] alu_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        ext_stall_i;
  logic [1:0]  ctrl_o;
  logic [31:0] wb_o;
  logic [4:0]  rd_o;
  logic        stall_o;
  logic        misalign_o;
  logic [31:0] stall_cnt_o;
  mem_state_e  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int rd_seen;
  int stall_seen;

  mem_stage_if #(.ADDR_W(30)) dc_if ();

  mem_stage #(.ENDIAN_SWAP(1'b1), .ADDR_W(30)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctrl_i      (ctrl_i),
    .ALUResult_i (alu_i),
    .RS2data_i   (rs2_i),
    .RDaddr_i    (rd_i),
    .ext_stall_i (ext_stall_i),
    .dc          (dc_if),
    .ctrl_o      (ctrl_o),
    .WBdata_o    (wb_o),
    .RDaddr_o    (rd_o),
    .stall_o     (stall_o),
    .misalign_o  (misalign_o),
    .stall_cnt_o (stall_cnt_o),
    .state_o     (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic dstall, input logic [31:0] rdata,
                       input logic ext);
    ctrl_i             = c;
    alu_i              = alu;
    rs2_i              = rs2;
    rd_i               = rd;
    dc_if.DCACHE_stall = dstall;
    dc_if.DCACHE_rdata = rdata;
    ext_stall_i        = ext;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    settle();
    check("reset_ren", {31'd0, dc_if.DCACHE_ren}, 32'd0);
    check("reset_wen", {31'd0, dc_if.DCACHE_wen}, 32'd0);
    rst_n = 1'b1;
    settle();
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    check("reset_cnt", stall_cnt_o, 32'd0);
    check("reset_misalign", {31'd0, misalign_o}, 32'd0);

    // ALU op passes straight through with no cache request
    drive(4'b1000, 32'hDEADBEEF, 32'd0, 5'd7, 1'b0, 32'h0, 1'b0);
    settle();
    check("alu_ren", {31'd0, dc_if.DCACHE_ren}, 32'd0);
    check("alu_wen", {31'd0, dc_if.DCACHE_wen}, 32'd0);
    check("alu_stall", {31'd0, stall_o}, 32'd0);
    check("alu_wb", wb_o, 32'hDEADBEEF);
    check("alu_ctrl", {30'd0, ctrl_o}, 32'd2);
    check("alu_rd", {27'd0, rd_o}, 32'd7);
    tick();

    // load hit
    drive(4'b1110, 32'h100, 32'd0, 5'd5, 1'b0, 32'h11223344, 1'b0);
    settle();
    check("hit_ren", {31'd0, dc_if.DCACHE_ren}, 32'd1);
    check("hit_wen", {31'd0, dc_if.DCACHE_wen}, 32'd0);
    check("hit_addr", {2'd0, dc_if.DCACHE_addr}, 32'h40);
    check("hit_wb", wb_o, 32'h44332211);
    check("hit_stall", {31'd0, stall_o}, 32'd0);
    check("hit_ctrl", {30'd0, ctrl_o}, 32'd3);
    tick();
    check("hit_state", {30'd0, state_dbg}, 32'd0);

    // both read and write set: read wins
    drive(4'b0011, 32'h10, 32'h1, 5'd0, 1'b0, 32'h0, 1'b0);
    settle();
    check("both_ren", {31'd0, dc_if.DCACHE_ren}, 32'd1);
    check("both_wen", {31'd0, dc_if.DCACHE_wen}, 32'd0);
    tick();

    // store miss with 3 busy cycles
    stall_seen = 0;
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 32'h200, 32'hAABBCCDD, 5'd0, (i < 3), 32'h0, 1'b0);
      settle();
      check("st_wen", {31'd0, dc_if.DCACHE_wen}, 32'd1);
      check("st_ren", {31'd0, dc_if.DCACHE_ren}, 32'd0);
      check("st_wdata", dc_if.DCACHE_wdata, 32'hDDCCBBAA);
      check("st_addr", {2'd0, dc_if.DCACHE_addr}, 32'h80);
      check("st_state", {30'd0, state_dbg}, (i == 0) ? 32'd0 : 32'd1);
      if (stall_o) stall_seen++;
      tick();
    end
    check("st_stall_cycles", stall_seen, 32'd3);
    check("st_cnt", stall_cnt_o, 32'd3);
    check("st_state_end", {30'd0, state_dbg}, 32'd0);

    // load completes while another source freezes the pipe for 2 more cycles
    rd_seen = 0;
    drive(4'b1110, 32'h300, 32'd0, 5'd9, 1'b0, 32'hCAFEF00D, 1'b1);
    settle();
    check("hold_ren0", {31'd0, dc_if.DCACHE_ren}, 32'd1);
    check("hold_stall0", {31'd0, stall_o}, 32'd0);
    check("hold_wb0", wb_o, 32'h0DF0FECA);
    if (dc_if.DCACHE_ren) rd_seen++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1110, 32'h300, 32'd0, 5'd9, 1'b1, 32'h12345678, (i < 2));
      settle();
      check("hold_state", {30'd0, state_dbg}, 32'd2);
      check("hold_ren", {31'd0, dc_if.DCACHE_ren}, 32'd0);
      check("hold_stall", {31'd0, stall_o}, 32'd0);
      check("hold_wb", wb_o, 32'h0DF0FECA);
      if (dc_if.DCACHE_ren) rd_seen++;
      tick();
    end
    check("hold_state_end", {30'd0, state_dbg}, 32'd0);
    check("hold_reads", rd_seen, 32'd1);
    check("hold_cnt", stall_cnt_o, 32'd3);

    // misaligned load then an aligned one
    drive(4'b1110, 32'h103, 32'd0, 5'd1, 1'b0, 32'h0, 1'b0);
    settle();
    check("mis_addr", {2'd0, dc_if.DCACHE_addr}, 32'h40);
    check("mis_pre", {31'd0, misalign_o}, 32'd0);
    tick();
    check("mis_set", {31'd0, misalign_o}, 32'd1);
    drive(4'b1110, 32'h104, 32'd0, 5'd1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(4'b1000, 32'h1, 32'd0, 5'd1, 1'b0, 32'h0, 1'b0);
    tick();
    check("mis_sticky", {31'd0, misalign_o}, 32'd1);

    // reset while waiting on a miss
    drive(4'b1110, 32'h400, 32'd0, 5'd2, 1'b1, 32'h0, 1'b0);
    tick();
    check("rst_wait_state", {30'd0, state_dbg}, 32'd1);
    check("rst_wait_cnt", stall_cnt_o, 32'd4);
    rst_n = 1'b0;
    settle();
    check("rst_ren_now", {31'd0, dc_if.DCACHE_ren}, 32'd0);
    check("rst_wen_now", {31'd0, dc_if.DCACHE_wen}, 32'd0);
    tick();
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_cnt", stall_cnt_o, 32'd0);
    check("rst_misalign", {31'd0, misalign_o}, 32'd0);
    rst_n = 1'b1;
    drive(4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 32'h0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
